// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
//   Bridges a byte-oriented SPI slave to a simple request/ack register bus.
//   The first byte of a frame is a command {rw, addr[6:0]}. Writes (rw=0)
//   consume the following bytes as data and auto-increment the address.
//   Reads (rw=1) fetch the addressed register right away so the byte is in
//   tx_data before the master clocks it out. Each further byte from the master
//   triggers a fetch of the next address (read prefetch).
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   ss         : slave select, active low, already in the clk domain
//   rx_data    : byte received from the SPI slave
//   rx_valid   : one-cycle strobe, rx_data valid
//   tx_data    : byte the SPI slave shifts out on the next transfer
//   reg_addr   : register address
//   reg_wdata  : register write data
//   reg_we     : write request, level, held until reg_ack
//   reg_re     : read request, level, held until reg_ack
//   reg_rdata  : read data, valid with reg_ack while reg_re=1
//   reg_ack    : access complete
//   busy       : controller not idle
//   err_overrun: sticky, a byte arrived while a bus access was pending
// ---------------------------------------------------------------------------
module spi_reg_ctrl #(
    // The command byte holds a 7-bit address, so 7 is the only usable width.
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ss,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_ack,
    output logic              busy,
    output logic              err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_WAIT = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_DATA = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;
    logic [7:0]        r_tx;
    logic              r_err;
    logic              r_abort;   // ss rose while an access was pending

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [7:0]        w_wdata_nxt;
    logic [7:0]        w_tx_nxt;
    logic              w_err_nxt;
    logic              w_abort_nxt;
    logic              w_end_frame;

    // An abort seen at any point during the wait ends the frame once the
    // access completes, even if ss has dropped again by then.
    assign w_end_frame = ss | r_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_wdata <= 8'h00;
            r_tx    <= 8'h00;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_tx    <= w_tx_nxt;
            r_err   <= w_err_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_tx_nxt    = r_tx;
        w_err_nxt   = r_err;
        w_abort_nxt = r_abort;

        case (r_state)
            S_IDLE: begin
                w_tx_nxt    = 8'h00;
                w_abort_nxt = 1'b0;
                if (!ss) w_state_nxt = S_CMD;
            end

            S_CMD: begin
                w_tx_nxt = 8'h00;
                if (ss) begin
                    w_state_nxt = S_IDLE;
                end else if (rx_valid) begin
                    w_addr_nxt  = rx_data[ADDR_W-1:0];
                    w_state_nxt = rx_data[7] ? S_RD_WAIT : S_WR_DATA;
                end
            end

            S_WR_DATA: begin
                if (ss) begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 8'h00;
                end else if (rx_valid) begin
                    w_wdata_nxt = rx_data;
                    w_state_nxt = S_WR_WAIT;
                end
            end

            S_WR_WAIT: begin
                if (ss) w_abort_nxt = 1'b1;
                // ss wins over a coincident byte: dropped silently
                if (rx_valid && !ss) w_err_nxt = 1'b1;
                if (reg_ack) begin
                    if (w_end_frame) begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 8'h00;
                        w_abort_nxt = 1'b0;
                    end else begin
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_WR_DATA;
                    end
                end
            end

            S_RD_WAIT: begin
                if (ss) w_abort_nxt = 1'b1;
                if (rx_valid && !ss) w_err_nxt = 1'b1;
                if (reg_ack) begin
                    if (w_end_frame) begin
                        w_state_nxt = S_IDLE;
                        w_tx_nxt    = 8'h00;
                        w_abort_nxt = 1'b0;
                    end else begin
                        w_tx_nxt    = reg_rdata;
                        w_addr_nxt  = r_addr + ADDR_W'(1);
                        w_state_nxt = S_RD_DATA;
                    end
                end
            end

            S_RD_DATA: begin
                if (ss) begin
                    w_state_nxt = S_IDLE;
                    w_tx_nxt    = 8'h00;
                end else if (rx_valid) begin
                    // master just shifted tx_data out; fetch the next byte
                    w_state_nxt = S_RD_WAIT;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 8'h00;
            end
        endcase
    end

    // Requests decode straight from state, so they can never overlap and
    // drop together with the state on reset.
    assign reg_we      = (r_state == S_WR_WAIT);
    assign reg_re      = (r_state == S_RD_WAIT);
    assign busy        = (r_state != S_IDLE);
    assign tx_data     = r_tx;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;
    assign err_overrun = r_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
module tb_spi_reg_ctrl;

    logic       clk;
    logic       reset;
    logic       ss;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       reg_ack;
    logic       busy;
    logic       err_overrun;

    spi_reg_ctrl #(.ADDR_W(7)) dut (
        .clk(clk), .reset(reset), .ss(ss), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .busy(busy), .err_overrun(err_overrun)
    );

    typedef struct {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
    } acc_t;

    acc_t       exp_q[$];
    logic [7:0] mem [0:127];
    int         n_cmp = 0;
    int         n_err = 0;
    int         ack_dly = 2;
    int         cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // Register file responder + scoreboard: each new request is popped
    // against the queue; ack comes ack_dly cycles after request assertion.
    initial begin
        acc_t e;
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                reg_ack = 1'b0;
                cnt     = 0;
            end else if (reg_ack) begin
                reg_ack = 1'b0;
                cnt     = 0;
            end else if (reg_we || reg_re) begin
                if (cnt == 0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL sb_unexpected: got we=%0b re=%0b addr=%h data=%h, required no access",
                                 reg_we, reg_re, reg_addr, reg_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({reg_we, reg_re, reg_addr} !== {e.we, ~e.we, e.addr} ||
                            (e.we && reg_wdata !== e.data)) begin
                            n_err++;
                            $display("FAIL sb_access: got we=%0b re=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                                     reg_we, reg_re, reg_addr, reg_wdata, e.we, e.addr, e.data);
                        end
                    end
                end
                cnt++;
                if (cnt >= ack_dly) begin
                    reg_ack = 1'b1;
                    if (reg_re) reg_rdata = mem[reg_addr];
                    if (reg_we) mem[reg_addr] = reg_wdata;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic push_acc(input logic we, input logic [6:0] a, input logic [7:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic set_ss(input logic v);
        @(posedge clk);
        #1 ss = v;
    endtask

    // one-cycle rx_valid strobe; returns 1 time unit after the consuming edge
    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(posedge clk);
            #1;
            if (!(reg_we || reg_re)) done = 1;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL wait_done: request still pending we=%0b re=%0b, required completion", reg_we, reg_re);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (tx_data !== 8'h00)     begin n_err++; $display("FAIL rst_tx: got %h, required 00", tx_data); end
        n_cmp++; if (reg_addr !== 7'h00)    begin n_err++; $display("FAIL rst_addr: got %h, required 00", reg_addr); end
        n_cmp++; if (reg_wdata !== 8'h00)   begin n_err++; $display("FAIL rst_wdata: got %h, required 00", reg_wdata); end
        n_cmp++; if (reg_we !== 1'b0)       begin n_err++; $display("FAIL rst_we: got %b, required 0", reg_we); end
        n_cmp++; if (reg_re !== 1'b0)       begin n_err++; $display("FAIL rst_re: got %b, required 0", reg_re); end
        n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++; if (err_overrun !== 1'b0)  begin n_err++; $display("FAIL rst_err: got %b, required 0", err_overrun); end
        @(posedge clk);
        #1 reset = 1'b0;
        // bytes while ss=1 are ignored
        send_rx(8'h05);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_ignore_rx: busy=%b, required 0", busy); end
    endtask

    task automatic test_write_burst();
        ack_dly = 2;
        push_acc(1'b1, 7'h05, 8'hAA);
        push_acc(1'b1, 7'h06, 8'h55);
        set_ss(1'b0);
        send_rx(8'h05);
        send_rx(8'hAA);
        n_cmp++; if (reg_we !== 1'b1 || reg_wdata !== 8'hAA)
            begin n_err++; $display("FAIL wr_latency: we=%b wdata=%h, required 1/AA", reg_we, reg_wdata); end
        wait_done();
        n_cmp++; if (reg_addr !== 7'h06 || busy !== 1'b1)
            begin n_err++; $display("FAIL wr_incr: addr=%h busy=%b, required 06/1", reg_addr, busy); end
        send_rx(8'h55);
        wait_done();
        set_ss(1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || err_overrun !== 1'b0)
            begin n_err++; $display("FAIL wr_end: busy=%b err=%b, required 0/0", busy, err_overrun); end
    endtask

    task automatic test_read();
        ack_dly = 2;
        mem[3] = 8'h41;
        mem[4] = 8'h42;
        push_acc(1'b0, 7'h03, 8'h00);
        push_acc(1'b0, 7'h04, 8'h00);
        set_ss(1'b0);
        send_rx(8'h83);
        n_cmp++; if (reg_re !== 1'b1 || reg_we !== 1'b0 || reg_addr !== 7'h03)
            begin n_err++; $display("FAIL rd_latency: re=%b we=%b addr=%h, required 1/0/03", reg_re, reg_we, reg_addr); end
        wait_done();
        n_cmp++; if (tx_data !== 8'h41 || reg_addr !== 7'h04)
            begin n_err++; $display("FAIL rd_first: tx=%h addr=%h, required 41/04", tx_data, reg_addr); end
        send_rx(8'h00);
        n_cmp++; if (reg_re !== 1'b1)
            begin n_err++; $display("FAIL rd_prefetch: re=%b, required 1", reg_re); end
        wait_done();
        n_cmp++; if (tx_data !== 8'h42)
            begin n_err++; $display("FAIL rd_second: tx=%h, required 42", tx_data); end
        set_ss(1'b1);
        @(posedge clk);
        #1;
        n_cmp++; if (tx_data !== 8'h00 || busy !== 1'b0)
            begin n_err++; $display("FAIL rd_end: tx=%h busy=%b, required 00/0", tx_data, busy); end
    endtask

    task automatic test_wrap();
        ack_dly = 2;
        push_acc(1'b1, 7'h7F, 8'h11);
        push_acc(1'b1, 7'h00, 8'h22);
        set_ss(1'b0);
        send_rx(8'h7F);
        send_rx(8'h11);
        wait_done();
        n_cmp++; if (reg_addr !== 7'h00)
            begin n_err++; $display("FAIL wrap_addr: got %h, required 00", reg_addr); end
        send_rx(8'h22);
        wait_done();
        set_ss(1'b1);
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abort();
        ack_dly = 6;
        push_acc(1'b1, 7'h20, 8'h44);
        set_ss(1'b0);
        send_rx(8'h20);
        send_rx(8'h44);
        ss = 1'b1;                        // abort while the write is pending
        @(posedge clk);
        #1;
        n_cmp++; if (reg_we !== 1'b1 || busy !== 1'b1)
            begin n_err++; $display("FAIL abort_hold: we=%b busy=%b, required 1/1", reg_we, busy); end
        wait_done();
        n_cmp++; if (busy !== 1'b0 || tx_data !== 8'h00)
            begin n_err++; $display("FAIL abort_idle: busy=%b tx=%h, required 0/00", busy, tx_data); end
        // abort in WR_DATA, with a coincident byte that must be dropped
        set_ss(1'b0);
        send_rx(8'h30);
        @(posedge clk);
        #1;
        ss = 1'b1; rx_data = 8'h77; rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
        n_cmp++; if (busy !== 1'b0 || reg_we !== 1'b0 || err_overrun !== 1'b0)
            begin n_err++; $display("FAIL abort_wrdata: busy=%b we=%b err=%b, required 0/0/0", busy, reg_we, err_overrun); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_overrun();
        ack_dly = 20;
        push_acc(1'b1, 7'h10, 8'h33);
        set_ss(1'b0);
        send_rx(8'h10);
        send_rx(8'h33);
        send_rx(8'h99);                   // arrives during WR_WAIT
        n_cmp++; if (err_overrun !== 1'b1)
            begin n_err++; $display("FAIL ovr_flag: got %b, required 1", err_overrun); end
        n_cmp++; if (reg_we !== 1'b1 || reg_wdata !== 8'h33 || reg_addr !== 7'h10)
            begin n_err++; $display("FAIL ovr_hold: we=%b wdata=%h addr=%h, required 1/33/10", reg_we, reg_wdata, reg_addr); end
        wait_done();
        set_ss(1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (err_overrun !== 1'b1)
            begin n_err++; $display("FAIL ovr_sticky: got %b, required 1", err_overrun); end
    endtask

    task automatic test_reset_mid_read();
        ack_dly = 30;
        push_acc(1'b0, 7'h05, 8'h00);
        set_ss(1'b0);
        send_rx(8'h85);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (reg_re !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || err_overrun !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_rd: re=%b tx=%h busy=%b err=%b, required 0/00/0/0",
                                    reg_re, tx_data, busy, err_overrun); end
        ss = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        reset = 1'b1; ss = 1'b1; rx_data = 8'h00; rx_valid = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        test_reset();
        test_write_burst();
        test_read();
        test_wrap();
        test_abort();
        test_overrun();
        test_reset_mid_read();
        repeat (5) @(posedge clk);
        n_cmp++; if (exp_q.size() != 0)
            begin n_err++; $display("FAIL sb_leftover: %0d expected accesses never seen, required 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width; the command byte carries {rw, addr[6:0]}, so only 7 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port ss  input  1  SPI slave select; active low; already synchronized to clk.
REQ-005 SHALL have port rx_data  input  8  received byte from spi_slave d.
REQ-006 SHALL have port rx_valid  input  1  one-cycle pulse from spi_slave finished; rx_data valid that cycle.
REQ-007 SHALL have port tx_data  output  8  byte to spi_slave q for the next transfer.
REQ-008 SHALL have port reg_addr  output  ADDR_W  register address.
REQ-009 SHALL have port reg_wdata  output  8  write data.
REQ-010 SHALL have port reg_we  output  1  write request; level, held until ack.
REQ-011 SHALL have port reg_re  output  1  read request; level, held until ack.
REQ-012 SHALL have port reg_rdata  input  8  read data; valid when reg_ack=1 and reg_re=1.
REQ-013 SHALL have port reg_ack  input  1  access complete.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port err_overrun  output  1  sticky overrun flag.

Function
REQ-016 SHALL implement states IDLE, CMD, WR_DATA, WR_WAIT, RD_WAIT, RD_DATA.
REQ-017 IDLE: ss=0 -> CMD next cycle; rx_valid ignored while ss=1.
REQ-018 CMD: tx_data=8'h00; on rx_valid latch addr<=rx_data[6:0]; rx_data[7]=0 -> WR_DATA; rx_data[7]=1 -> RD_WAIT with reg_re=1 from the next cycle.
REQ-019 WR_DATA: on rx_valid -> reg_wdata<=rx_data, reg_we=1 from the next cycle, -> WR_WAIT.
REQ-020 WR_WAIT: hold reg_we, reg_addr, reg_wdata stable until reg_ack=1; cycle after ack: reg_we=0, addr<=addr+1, -> WR_DATA.
REQ-021 RD_WAIT: hold reg_re and reg_addr until reg_ack=1; on ack tx_data<=reg_rdata; cycle after ack: reg_re=0, addr<=addr+1, -> RD_DATA.
REQ-022 RD_DATA: on rx_valid (master clocked out tx_data; received byte discarded) -> RD_WAIT, fetching the next byte (read prefetch).
REQ-023 Address increment SHALL wrap 7'h7F -> 7'h00.
REQ-024 reg_ack while neither reg_we nor reg_re is high SHALL be ignored.
REQ-025 reg_we and reg_re SHALL never be high together.
REQ-026 rx_valid in WR_WAIT or RD_WAIT SHALL be dropped and set err_overrun=1 next cycle; state unchanged.
REQ-027 err_overrun SHALL clear only on reset.
REQ-028 ss=1 in CMD, WR_DATA or RD_DATA SHALL return to IDLE next cycle; tx_data<=8'h00.
REQ-029 ss=1 in WR_WAIT or RD_WAIT SHALL hold the request until reg_ack, then go to IDLE; read data is then discarded and tx_data<=8'h00.
REQ-030 rx_valid and ss=1 in the same cycle SHALL give priority to ss; the byte is dropped without error.
REQ-031 Request assertion latency SHALL be exactly 1 cycle after the rx_valid cycle.

Reset
REQ-032 Reset SHALL force: state IDLE; tx_data=8'h00; reg_addr=0; reg_wdata=0; reg_we=0; reg_re=0; busy=0; err_overrun=0.
REQ-033 Reset SHALL take priority over all other inputs, including mid-access (request dropped without waiting for ack).

Verification
REQ-034 Write burst: ss=0, rx 8'h05, 8'hAA, 8'h55, ack 2 cycles after each request -> reg_we addr 5 data AA, then addr 6 data 55; err_overrun=0.
REQ-035 Read: reg file addr 3 = 8'h41, addr 4 = 8'h42; rx 8'h83 -> reg_re addr 3, tx_data=8'h41; after next rx_valid, reg_re addr 4, tx_data=8'h42.
REQ-036 Wrap: command 8'h7F write, two data bytes -> writes to addr 7F then 00.
REQ-037 Overrun: ack delayed 20 cycles; second rx_valid during WR_WAIT -> byte dropped, err_overrun=1 until reset.
REQ-038 Abort: ss=1 during WR_WAIT -> reg_we held until ack, then IDLE with busy=0; ss=1 in WR_DATA -> IDLE next cycle, no write.
REQ-039 Reset mid-RD_WAIT -> next cycle reg_re=0, tx_data=8'h00, busy=0.
